imem_loader_ctrl: RTL

//  Sequences program-memory initialisation for the 5-stage RISC-V core. Clears the 32-word program memory, then streams words in

---
 rtl/riscv_pkg.sv | 29 ++
 rtl/imem_loader_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_pkg
// Description : Shared definitions for the RISC-V core support blocks:
//               program memory depth, loader state encoding, and loader
//               error codes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Program memory depth in 32-bit words
    localparam int DEPTH = 32;

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } loader_state_t;

    // Loader error codes
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_TMO  = 2'b10;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imem_loader_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_ctrl
// Description : Program-memory initialisation sequencer. Clears every word of
//               program memory, then writes a streamed image at ascending word
//               addresses, holding the core in reset until the image is in.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader_ctrl #(
    parameter int DEPTH   = riscv_pkg::DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          s_valid,
    input  logic [31:0]   s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          pmem_we,
    output logic [AW-1:0] pmem_addr,
    output logic [31:0]   pmem_wdata,
    output logic          core_rst,
    output logic          done,
    output logic          error,
    output logic [1:0]    err_code,
    output logic [AW:0]   word_count,
    output logic [31:0]   checksum
);

    import riscv_pkg::*;

    localparam int          TW         = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] C_FULL     = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] C_LAST   = AW'(DEPTH - 1);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT - 1);

    loader_state_t   r_state;
    loader_state_t   w_state_nxt;
    logic [AW-1:0]   r_clr_cnt;
    logic [AW-1:0]   w_clr_cnt;
    logic [TW-1:0]   r_idle_cnt;
    logic [TW-1:0]   w_idle_cnt;
    logic            r_we;
    logic            w_we;
    logic [AW-1:0]   r_addr;
    logic [AW-1:0]   w_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     w_wdata;
    logic [AW:0]     r_word_count;
    logic [AW:0]     w_word_count;
    logic [31:0]     r_checksum;
    logic [31:0]     w_checksum;
    logic [1:0]      r_err_code;
    logic [1:0]      w_err_code;
    logic            r_core_rst;
    logic            w_core_rst;
    logic            w_go;

    // State and datapath registers; rst returns everything to the idle image
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_clr_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_word_count <= '0;
            r_checksum   <= '0;
            r_err_code   <= ERR_NONE;
            r_core_rst   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_clr_cnt    <= w_clr_cnt;
            r_idle_cnt   <= w_idle_cnt;
            r_we         <= w_we;
            r_addr       <= w_addr;
            r_wdata      <= w_wdata;
            r_word_count <= w_word_count;
            r_checksum   <= w_checksum;
            r_err_code   <= w_err_code;
            r_core_rst   <= w_core_rst;
        end
    end

    // Next-state and next-register values for clear, load, run and error
    always_comb begin
        w_state_nxt  = r_state;
        w_clr_cnt    = r_clr_cnt;
        w_idle_cnt   = r_idle_cnt;
        w_we         = 1'b0;
        w_addr       = r_addr;
        w_wdata      = r_wdata;
        w_word_count = r_word_count;
        w_checksum   = r_checksum;
        w_err_code   = r_err_code;
        w_go         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_go = start;
            end
            ST_CLEAR: begin
                // pmem_we was raised on entry; keep writing zeros until the
                // last address has been presented
                if (r_clr_cnt == C_LAST) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_we      = 1'b1;
                    w_clr_cnt = r_clr_cnt + 1'b1;
                    w_addr    = r_clr_cnt + 1'b1;
                end
            end
            ST_LOAD: begin
                if (s_valid) begin
                    w_idle_cnt = '0;
                    if (r_word_count < C_FULL) begin
                        w_we         = 1'b1;
                        w_addr       = r_word_count[AW-1:0];
                        w_wdata      = s_data;
                        w_word_count = r_word_count + 1'b1;
                        w_checksum   = r_checksum + s_data;
                        if (s_last) begin
                            w_state_nxt = ST_RUN;
                        end
                    end else begin
                        // Image already fills memory: swallow the beat
                        w_state_nxt = ST_ERROR;
                        w_err_code  = ERR_OVF;
                    end
                end else if (r_idle_cnt == C_TMO_LAST) begin
                    w_state_nxt = ST_ERROR;
                    w_err_code  = ERR_TMO;
                end else begin
                    w_idle_cnt = r_idle_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_go = start;
            end
            ST_ERROR: begin
                w_go = start;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A new sequence begins with the first clear write already presented
        if (w_go) begin
            w_state_nxt  = ST_CLEAR;
            w_clr_cnt    = '0;
            w_idle_cnt   = '0;
            w_we         = 1'b1;
            w_addr       = '0;
            w_wdata      = '0;
            w_word_count = '0;
            w_checksum   = '0;
            w_err_code   = ERR_NONE;
        end

        // Release the core only once RUN has been entered and is being held,
        // so the final image write lands while the core is still in reset
        w_core_rst = !((r_state == ST_RUN) && (w_state_nxt == ST_RUN));
    end

    assign s_ready    = (r_state == ST_LOAD);
    assign done       = (r_state == ST_RUN);
    assign error      = (r_state == ST_ERROR);
    assign pmem_we    = r_we;
    assign pmem_addr  = r_addr;
    assign pmem_wdata = r_wdata;
    assign core_rst   = r_core_rst;
    assign err_code   = r_err_code;
    assign word_count = r_word_count;
    assign checksum   = r_checksum;

endmodule : imem_loader_ctrl
`default_nettype wire
